sum_seq: RTL and testbench
==========================

Name: sum_seq

Overview:
- Sequencing wrapper placed directly around the combinational `sum` adder stage.
- Accepts an operand pair and a condition code over a valid/ready handshake, and drives A/B into the adder.
- Waits a fixed settle window, then latches the adder's R and CCR (C,V,N,Z) into registers.
- Presents the registered result plus an evaluated branch condition downstream over valid/ready.

Parameters:
- OP_SIZE, 4, operand/result width; must match the adder's op_size.
- SETTLE_CYCLES, 5, clock cycles between driving operands and sampling R/CCR; legal range 1..15.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands.
- in_a  input  OP_SIZE  operand A.
- in_b  input  OP_SIZE  operand B.
- in_cond  input  3  condition select, latched with the operands.
- sum_a  output  OP_SIZE  registered A driven to the adder.
- sum_b  output  OP_SIZE  registered B driven to the adder.
- sum_r  input  OP_SIZE  adder result.
- sum_ccr  input  4  adder CCR; bit3=C, bit2=V, bit1=N, bit0=Z.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_r  output  OP_SIZE  latched result.
- out_ccr  output  4  latched CCR, same bit order as sum_ccr.
- out_cond  output  1  selected condition evaluated on out_ccr.

Behaviour:
- Reset: synchronous, active-low. While rst_n=0 at a rising edge:
  - state goes to IDLE;
  - sum_a, sum_b, out_r, out_ccr, out_cond and the settle counter go to 0;
  - out_valid goes to 0;
  - in_ready is 0 during reset and 1 on the first cycle after rst_n returns high.
  - Reset mid-operation discards the operation; no result is ever emitted for it.
- The FSM is Moore. States:
  - IDLE: in_ready=1, out_valid=0. On in_valid=1, the edge latches in_a/in_b into sum_a/sum_b, latches in_cond, loads cnt=SETTLE_CYCLES-1, and moves to SETTLE.
  - SETTLE: in_ready=0, out_valid=0. Each edge with cnt!=0 decrements cnt. The edge with cnt==0 samples sum_r into out_r and sum_ccr into out_ccr, registers out_cond, and moves to HOLD.
  - HOLD: in_ready=0, out_valid=1. While out_ready=0, out_r, out_ccr and out_cond remain stable. The edge with out_ready=1 moves to IDLE, clears out_valid and leaves out_r/out_ccr unchanged.
- Latency: out_valid is high exactly SETTLE_CYCLES cycles after the accept edge.
- Throughput: at most one op per SETTLE_CYCLES+2 cycles. There is no overlap; in_ready is never high while a result is pending.
- sum_a/sum_b stay stable from accept until the next accept; the adder inputs never change inside a settle window.
- Input changes while in_ready=0 are ignored.
- out_cond encodings (cond registered at accept), evaluated on the captured CCR:
  - 0 EQ = Z, 1 NE = !Z
  - 2 CS = C, 3 CC = !C
  - 4 MI = N, 5 PL = !N
  - 6 VS = V, 7 VC = !V
- Wrap-around: R is modulo 2^OP_SIZE, exactly as the adder produces it; this block performs no arithmetic on R.

Optional Feature:
- Macro: SUM_SEQ_CCR_CHECK_EN.
- Defined:
  - Adds output ccr_err (1 bit, reset 0).
  - At the capture edge the block locally computes reference flags from the latched operands:
    - C = carry out of the OP_SIZE-bit add;
    - V = (A_msb==B_msb) && (R_msb!=A_msb);
    - N = R_msb;
    - Z = (R==0).
  - ccr_err is set to 1 when any flag differs from sum_ccr or sum_r != A+B (mod 2^OP_SIZE).
  - ccr_err is valid alongside out_valid and is cleared at the next accept.
- Undefined: no ccr_err port and no checker logic; behaviour is otherwise identical.

Decomposition:
- Package sum_seq_pkg holds:
  - CCR bit indices C_BIT=3, V_BIT=2, N_BIT=1, Z_BIT=0;
  - the matching masks;
  - cond encodings COND_EQ..COND_VC;
  - state enum IDLE/SETTLE/HOLD.
- Sub-module sum_cond_eval (combinational: 3-bit cond and 4-bit ccr in, 1-bit result out), shared later by branch logic.

Test Plan (OP_SIZE=4, SETTLE_CYCLES=5, bench adder model with correct flags):
- Reset: rst_n=0 for 2 cycles, then high → all outputs 0, in_ready=1 next cycle, out_valid=0.
- Basic op: A=3, B=4, cond=PL, out_ready=1 → out_valid exactly 5 cycles after accept; out_r=7, out_ccr=0000, out_cond=1.
- Flags: A=8, B=8, cond=EQ → out_r=0, out_ccr=1101, out_cond=1. Then A=7, B=1, cond=VS → out_r=8, out_ccr=0110, out_cond=1.
- Backpressure: result pending, out_ready=0 for 10 cycles; change in_a/in_b/in_valid meanwhile → outputs stable, in_ready=0, new inputs ignored; out_ready=1 → IDLE next cycle.
- Mid-operation reset: assert rst_n=0 in SETTLE at cnt=2 → IDLE, no out_valid pulse, next op A=1, B=1 → out_r=2.
- With SUM_SEQ_CCR_CHECK_EN: bench adder forces V=0 on A=7, B=1 → ccr_err=1. Correct model → ccr_err=0 for all 256 operand pairs.

Source files
------------

// File: rtl/sum_seq_pkg.sv
// Shared constants for the sum sequencing wrapper:
// CCR bit layout, branch condition codes, FSM states.
package sum_seq_pkg;

  localparam int C_BIT = 3;
  localparam int V_BIT = 2;
  localparam int N_BIT = 1;
  localparam int Z_BIT = 0;

  localparam logic [3:0] C_MASK = 4'b1000;
  localparam logic [3:0] V_MASK = 4'b0100;
  localparam logic [3:0] N_MASK = 4'b0010;
  localparam logic [3:0] Z_MASK = 4'b0001;

  localparam logic [2:0] COND_EQ = 3'd0;
  localparam logic [2:0] COND_NE = 3'd1;
  localparam logic [2:0] COND_CS = 3'd2;
  localparam logic [2:0] COND_CC = 3'd3;
  localparam logic [2:0] COND_MI = 3'd4;
  localparam logic [2:0] COND_PL = 3'd5;
  localparam logic [2:0] COND_VS = 3'd6;
  localparam logic [2:0] COND_VC = 3'd7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_e;

endpackage

// File: rtl/sum_cond_eval.sv
// Branch condition evaluator on a C,V,N,Z CCR.
// Ports: cond_i (3b code), ccr_i (4b), res_o (1b).
module sum_cond_eval
  import sum_seq_pkg::*;
(
  input  logic [2:0] cond_i,
  input  logic [3:0] ccr_i,
  output logic       res_o
);

  logic flag;

  // Code pairs share one flag; the low bit inverts it.
  always_comb begin
    flag = 1'b0;
    unique case (cond_i[2:1])
      2'd0: flag = ccr_i[Z_BIT];
      2'd1: flag = ccr_i[C_BIT];
      2'd2: flag = ccr_i[N_BIT];
      2'd3: flag = ccr_i[V_BIT];
      default: flag = 1'b0;
    endcase
    res_o = flag ^ cond_i[0];
  end

endmodule

// File: rtl/sum_seq.sv
// Sequencer around the combinational sum adder: accept, settle, capture, hold.
// Ports: in_* handshake/operands, sum_* adder side, out_* result handshake;
// ccr_err only when SUM_SEQ_CCR_CHECK_EN is defined.
module sum_seq
  import sum_seq_pkg::*;
#(
  parameter int OP_SIZE       = 4,
  parameter int SETTLE_CYCLES = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_SIZE-1:0] in_a,
  input  logic [OP_SIZE-1:0] in_b,
  input  logic [2:0]         in_cond,
  output logic [OP_SIZE-1:0] sum_a,
  output logic [OP_SIZE-1:0] sum_b,
  input  logic [OP_SIZE-1:0] sum_r,
  input  logic [3:0]         sum_ccr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OP_SIZE-1:0] out_r,
  output logic [3:0]         out_ccr,
`ifdef SUM_SEQ_CCR_CHECK_EN
  output logic               ccr_err,
`endif
  output logic               out_cond
);

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [OP_SIZE-1:0] a_q, b_q, r_q;
  logic [2:0]         cond_q;
  logic [3:0]         ccr_q;
  logic               oc_q;
  logic               oc_d;
  logic               accept;
  logic               capture;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          cnt_d   = 4'(SETTLE_CYCLES - 1);
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          capture = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  sum_cond_eval u_cond (
    .cond_i (cond_q),
    .ccr_i  (sum_ccr),
    .res_o  (oc_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cond_q  <= '0;
      r_q     <= '0;
      ccr_q   <= '0;
      oc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        a_q    <= in_a;
        b_q    <= in_b;
        cond_q <= in_cond;
      end
      if (capture) begin
        r_q   <= sum_r;
        ccr_q <= sum_ccr;
        oc_q  <= oc_d;
      end
    end
  end

`ifdef SUM_SEQ_CCR_CHECK_EN
  logic [OP_SIZE:0]   full;
  logic [OP_SIZE-1:0] ref_r;
  logic [3:0]         ref_ccr;
  logic               chk;
  logic               err_q;

  // Independent flag reference from the latched operands.
  always_comb begin
    full  = {1'b0, a_q} + {1'b0, b_q};
    ref_r = full[OP_SIZE-1:0];
    ref_ccr        = '0;
    ref_ccr[C_BIT] = full[OP_SIZE];
    ref_ccr[V_BIT] = (a_q[OP_SIZE-1] == b_q[OP_SIZE-1]) &&
                     (ref_r[OP_SIZE-1] != a_q[OP_SIZE-1]);
    ref_ccr[N_BIT] = ref_r[OP_SIZE-1];
    ref_ccr[Z_BIT] = (ref_r == '0);
    chk = (ref_ccr != sum_ccr) || (ref_r != sum_r);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)       err_q <= 1'b0;
    else if (accept)  err_q <= 1'b0;
    else if (capture) err_q <= chk;
  end

  assign ccr_err = err_q;
`endif

  // Gated by rst_n so the handshake stays closed while reset is held.
  assign in_ready  = rst_n && (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign sum_a     = a_q;
  assign sum_b     = b_q;
  assign out_r     = r_q;
  assign out_ccr   = ccr_q;
  assign out_cond  = oc_q;

endmodule

// File: tb/tb_sum_seq.sv
// Self-checking bench for sum_seq with a behavioural adder and reference model.
// Define SUM_SEQ_CCR_CHECK_EN to also exercise ccr_err.
module tb_sum_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a, in_b;
  logic [2:0] in_cond;
  logic [3:0] sum_a, sum_b, sum_r;
  logic [3:0] sum_ccr;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_r;
  logic [3:0] out_ccr;
  logic       out_cond;
`ifdef SUM_SEQ_CCR_CHECK_EN
  logic       ccr_err;
`endif

  int total = 0;
  int bad   = 0;
  bit force_v0 = 1'b0;
  bit exp_err  = 1'b0;

  always #5 clk = ~clk;

  sum_seq #(.OP_SIZE(4), .SETTLE_CYCLES(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cond   (in_cond),
    .sum_a     (sum_a),
    .sum_b     (sum_b),
    .sum_r     (sum_r),
    .sum_ccr   (sum_ccr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_ccr   (out_ccr),
`ifdef SUM_SEQ_CCR_CHECK_EN
    .ccr_err   (ccr_err),
`endif
    .out_cond  (out_cond)
  );

  // Behavioural adder stage, optionally with a broken V flag for 7+1.
  always_comb begin
    int s, sa, sb, ss;
    s  = int'(sum_a) + int'(sum_b);
    sa = (sum_a > 7) ? int'(sum_a) - 16 : int'(sum_a);
    sb = (sum_b > 7) ? int'(sum_b) - 16 : int'(sum_b);
    ss = sa + sb;
    sum_r      = 4'(s % 16);
    sum_ccr[3] = (s > 15);
    sum_ccr[2] = (ss > 7) || (ss < -8);
    sum_ccr[1] = (s % 16) > 7;
    sum_ccr[0] = (s % 16) == 0;
    if (force_v0 && sum_a == 4'd7 && sum_b == 4'd1) sum_ccr[2] = 1'b0;
  end

  function automatic void model(input int a, input int b, input int c,
                                output int r, output int ccr,
                                output int cnd);
    int s, sa, sb, ss;
    bit fc, fv, fn, fz;
    s  = a + b;
    r  = s % 16;
    sa = (a > 7) ? a - 16 : a;
    sb = (b > 7) ? b - 16 : b;
    ss = sa + sb;
    fc = (s > 15);
    fv = (ss > 7) || (ss < -8);
    fn = (r > 7);
    fz = (r == 0);
    ccr = 8 * int'(fc) + 4 * int'(fv) + 2 * int'(fn) + int'(fz);
    case (c)
      0: cnd = fz;
      1: cnd = !fz;
      2: cnd = fc;
      3: cnd = !fc;
      4: cnd = fn;
      5: cnd = !fn;
      6: cnd = fv;
      default: cnd = !fv;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction; `hold` cycles of backpressure with junk inputs.
  task automatic run_op(input int a, input int b, input int c,
                        input int hold, input bit vfault);
    int r, ccr, cnd, k;
    model(a, b, c, r, ccr, cnd);
    if (vfault) ccr = ccr & ~4;
    out_ready = 1'b0;
    in_a = 4'(a);
    in_b = 4'(b);
    in_cond = 3'(c);
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 20) begin
      tick();
      k++;
    end
    check("in_ready_idle", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("sum_a_accept", 32'(sum_a), 32'(a));
    check("sum_b_accept", 32'(sum_b), 32'(b));
    k = 0;
    while (!out_valid && k < 20) begin
      check("in_ready_settle", 32'(in_ready), 32'd0);
      in_a = 4'($urandom);
      in_b = 4'($urandom);
      in_valid = 1'($urandom);
      tick();
      k++;
    end
    in_valid = 1'b0;
    check("latency", 32'(k), 32'd5);
    check("sum_a_stable", 32'(sum_a), 32'(a));
    check("sum_b_stable", 32'(sum_b), 32'(b));
    check("out_r", 32'(out_r), 32'(r));
    check("out_ccr", 32'(out_ccr), 32'(ccr));
    check("out_cond", 32'(out_cond), 32'(cnd));
`ifdef SUM_SEQ_CCR_CHECK_EN
    check("ccr_err", 32'(ccr_err), 32'(vfault));
`endif
    repeat (hold) begin
      in_a = 4'($urandom);
      in_b = 4'($urandom);
      in_valid = 1'($urandom);
      tick();
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_ready", 32'(in_ready), 32'd0);
      check("hold_r", 32'(out_r), 32'(r));
      check("hold_ccr", 32'(out_ccr), 32'(ccr));
      check("hold_cond", 32'(out_cond), 32'(cnd));
      check("hold_sum_a", 32'(sum_a), 32'(a));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("release_valid", 32'(out_valid), 32'd0);
    check("release_ready", 32'(in_ready), 32'd1);
    check("release_r", 32'(out_r), 32'(r));
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_a = '0;
    in_b = '0;
    in_cond = '0;

    repeat (2) tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum_a", 32'(sum_a), 32'd0);
    check("rst_sum_b", 32'(sum_b), 32'd0);
    check("rst_out_r", 32'(out_r), 32'd0);
    check("rst_out_ccr", 32'(out_ccr), 32'd0);
    check("rst_out_cond", 32'(out_cond), 32'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", 32'(in_ready), 32'd1);
    check("post_rst_valid", 32'(out_valid), 32'd0);

    run_op(3, 4, 5, 0, 1'b0);
    run_op(8, 8, 0, 0, 1'b0);
    run_op(7, 1, 6, 0, 1'b0);
    run_op(9, 5, 2, 10, 1'b0);

    // Reset while two settle cycles remain.
    in_a = 4'd5;
    in_b = 4'd6;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd0);
    check("midrst_sum_a", 32'(sum_a), 32'd0);
    rst_n = 1'b1;
    #1;
    check("midrst_ready_after", 32'(in_ready), 32'd1);
    repeat (8) begin
      tick();
      check("midrst_no_valid", 32'(out_valid), 32'd0);
    end
    run_op(1, 1, 0, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_op(int'($urandom_range(15)), int'($urandom_range(15)),
             int'($urandom_range(7)), int'($urandom_range(3)), 1'b0);
    end

`ifdef SUM_SEQ_CCR_CHECK_EN
    force_v0 = 1'b1;
    run_op(7, 1, 4, 0, 1'b1);
    force_v0 = 1'b0;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(a, b, (a + b) % 8, 0, 1'b0);
      end
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
